lpram_port_ctrl: RTL and testbench
==================================

LPRAM_PORT_CTRL -- requirements
Module: lpram_port_ctrl

Interface
REQ-001 Parameter NUM_CH, default 2: client channel count (1..8).
REQ-002 Parameter ADDR_W, default 30: byte-address width.
REQ-003 Parameter DATA_W, default 32: data word width, a multiple of 8.
REQ-004 clk  in  1  system clock; the single clock for all logic, also the MCB cmd/wr/rd port clock.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 calib_done  in  1  MCB calibration complete.
REQ-007 ch_req  in  NUM_CH  per-channel request; held high until that channel's ch_done.
REQ-008 ch_we  in  NUM_CH  1 = write, 0 = read.
REQ-009 ch_addr  in  NUM_CH*ADDR_W  byte address per channel, flattened.
REQ-010 ch_bl  in  NUM_CH*6  burst length minus 1 per channel.
REQ-011 ch_wdata  in  NUM_CH*DATA_W  write word per channel.
REQ-012 ch_wnext  out  NUM_CH  one-hot pulse: granted channel's ch_wdata is consumed this cycle.
REQ-013 ch_rvalid  out  NUM_CH  one-hot pulse: rdata is valid for that channel.
REQ-014 rdata  out  DATA_W  read word, shared by all channels.
REQ-015 ch_done  out  NUM_CH  one-hot, one-cycle completion pulse.
REQ-016 cmd_en, cmd_instr[2:0], cmd_bl[5:0], cmd_byte_addr[ADDR_W-1:0]  out  MCB command port.
REQ-017 cmd_full  in  1  MCB command FIFO full.
REQ-018 wr_en, wr_mask[DATA_W/8-1:0], wr_data[DATA_W-1:0]  out  MCB write port.
REQ-019 wr_full  in  1  MCB write FIFO full.
REQ-020 rd_en  out  1; rd_data  in  DATA_W; rd_empty  in  1  MCB read port.

Function
REQ-021 States: WAIT_CAL, IDLE, WR_DATA, WR_CMD, RD_CMD, RD_DATA, DONE.
REQ-022 WAIT_CAL -> IDLE on the first cycle calib_done=1; IDLE -> WAIT_CAL if calib_done=0.
REQ-023 IDLE with any ch_req and calib_done: round-robin grant starting at the pointer; grant, address, bl and we are latched; next state is WR_DATA (we=1) or RD_CMD (we=0).
REQ-024 The pointer resets to channel 0 and is set to granted+1 (mod NUM_CH) at each grant.
REQ-025 WR_DATA: each cycle wr_full=0, assert wr_en with wr_data = granted ch_wdata, and pulse ch_wnext; after bl+1 words go to WR_CMD; stall with no pulse while wr_full=1.
REQ-026 WR_CMD and RD_CMD: assert cmd_en for one cycle when cmd_full=0; instr is 3'b000 for write and 3'b001 for read; cmd_bl = latched bl; cmd_byte_addr = latched address with bits [1:0] forced to 0.
REQ-027 After the command: write -> DONE; read -> RD_DATA.
REQ-028 RD_DATA: rd_en = ~rd_empty; in the same cycle drive rdata = rd_data and pulse ch_rvalid; after bl+1 words go to DONE.
REQ-029 DONE: pulse ch_done for the granted channel for one cycle, then return to IDLE; the next grant is possible no earlier than the following cycle.
REQ-030 wr_mask is always all-zero (all bytes written).
REQ-031 A calib_done drop mid-transaction is ignored until DONE.
REQ-032 Word counter is 7 bits, so bl=63 (64 words) causes no wrap.

Reset
REQ-033 On rst: state WAIT_CAL, pointer 0, and every output 0.
REQ-034 Reset mid-burst aborts the transaction without ch_done; MCB FIFO contents are not flushed.

Configuration
REQ-035 With LPRAM_CTRL_TIMEOUT_EN defined: in RD_DATA or WR_CMD, 1024 consecutive stalled cycles force DONE; ch_done and a one-cycle err output pulse together.
REQ-036 Without LPRAM_CTRL_TIMEOUT_EN: the err port is absent and there is no timeout; the block waits indefinitely.

Structure
REQ-037 Package lpram_ctrl_pkg holds the state typedef, the MCB instr constants (WRITE=3'b000, READ=3'b001) and TIMEOUT_CYC=1024.
REQ-038 Round-robin grant logic is sub-module rr_arbiter (NUM_CH parameter; req and pointer in; one-hot grant out).

Verification
REQ-039 calib_done held 0 for 50 cycles with ch_req=01 -> no cmd_en, no ch_wnext, no ch_rvalid, no ch_done.
REQ-040 ch0 write, addr 0x103, bl=3 -> 4 wr_en/ch_wnext pulses, then cmd_en instr 000, bl 3, addr 0x100, then ch_done=01.
REQ-041 ch1 read bl=7, rd_empty toggling every cycle -> exactly 8 ch_rvalid=10 pulses with matching rdata, then ch_done=10.
REQ-042 ch_req=11 held through 4 transactions -> grant order 0,1,0,1.
REQ-043 wr_full=1 for 10 cycles mid-burst -> wr_en stays 0 and the burst resumes with no word lost or duplicated.
REQ-044 rst asserted mid RD_DATA -> outputs 0 and WAIT_CAL the next cycle; with LPRAM_CTRL_TIMEOUT_EN, rd_empty stuck at 1 -> err and ch_done at cycle 1024.

Source files
------------

// File: rtl/lpram_ctrl_pkg.sv
// Shared types and constants for the LPDDR MCB port controller.
package lpram_ctrl_pkg;

    typedef enum logic [2:0] {
        WAIT_CAL,
        IDLE,
        WR_DATA,
        WR_CMD,
        RD_CMD,
        RD_DATA,
        DONE
    } state_e;

    localparam logic [2:0] WRITE = 3'b000;
    localparam logic [2:0] READ  = 3'b001;

    localparam int TIMEOUT_CYC = 1024;
    localparam int STALL_W     = $clog2(TIMEOUT_CYC);

endpackage

// File: rtl/lpram_port_ctrl_if.sv
// MCB command/write/read port bundle; master = controller side, slave = memory side.
interface lpram_port_ctrl_if #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
);
    logic                  cmd_en;
    logic [2:0]            cmd_instr;
    logic [5:0]            cmd_bl;
    logic [ADDR_W-1:0]     cmd_byte_addr;
    logic                  cmd_full;
    logic                  wr_en;
    logic [DATA_W/8-1:0]   wr_mask;
    logic [DATA_W-1:0]     wr_data;
    logic                  wr_full;
    logic                  rd_en;
    logic [DATA_W-1:0]     rd_data;
    logic                  rd_empty;

    modport master (
        output cmd_en, cmd_instr, cmd_bl, cmd_byte_addr, wr_en, wr_mask, wr_data, rd_en,
        input  cmd_full, wr_full, rd_data, rd_empty
    );

    modport slave (
        input  cmd_en, cmd_instr, cmd_bl, cmd_byte_addr, wr_en, wr_mask, wr_data, rd_en,
        output cmd_full, wr_full, rd_data, rd_empty
    );
endinterface

// File: rtl/lpram_port_ctrl_rr_arbiter.sv
// Round-robin arbiter: the first requester at or after ptr_i (wrapping) wins.
module rr_arbiter #(
    parameter int  NUM_CH = 2,
    localparam int PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [PTR_W-1:0]  ptr_i,
    output logic [NUM_CH-1:0] grant_o
);
    logic [NUM_CH-1:0]   req_rot;
    logic [NUM_CH-1:0]   gnt_rot;
    logic [2*NUM_CH-1:0] gnt_dbl;

    // Rotate so the pointer channel sits at bit 0, isolate the lowest set bit, rotate back.
    assign req_rot = NUM_CH'({req_i, req_i} >> ptr_i);
    assign gnt_rot = req_rot & (~req_rot + NUM_CH'(1));
    assign gnt_dbl = {{NUM_CH{1'b0}}, gnt_rot} << ptr_i;
    assign grant_o = gnt_dbl[NUM_CH-1:0] | gnt_dbl[2*NUM_CH-1:NUM_CH];
endmodule

// File: rtl/lpram_port_ctrl.sv
// Multi-channel client front end for one MCB port: round-robin grant, burst write/read, done pulse.
// Optional stall timeout with err output: define LPRAM_CTRL_TIMEOUT_EN.
module lpram_port_ctrl
    import lpram_ctrl_pkg::*;
#(
    parameter int  NUM_CH = 2,
    parameter int  ADDR_W = 30,
    parameter int  DATA_W = 32,
    localparam int PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     calib_done,
    input  logic [NUM_CH-1:0]        ch_req,
    input  logic [NUM_CH-1:0]        ch_we,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    input  logic [NUM_CH*6-1:0]      ch_bl,
    input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
    output logic [NUM_CH-1:0]        ch_wnext,
    output logic [NUM_CH-1:0]        ch_rvalid,
    output logic [DATA_W-1:0]        rdata,
    output logic [NUM_CH-1:0]        ch_done,
    lpram_port_ctrl_if.master        bus
`ifdef LPRAM_CTRL_TIMEOUT_EN
    ,
    output logic                     err
`endif
);
    state_e              state_q;
    logic [PTR_W-1:0]    ptr_q;
    logic [NUM_CH-1:0]   grant_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [5:0]          bl_q;
    logic [6:0]          cnt_q;

    logic [NUM_CH-1:0]   arb_grant;
    logic [PTR_W-1:0]    nxt_ptr;
    logic [ADDR_W-1:0]   sel_addr;
    logic [5:0]          sel_bl;
    logic                sel_we;
    logic [DATA_W-1:0]   wdata_sel;
    logic                last_word, in_cmd, wr_fire, rd_fire;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req_i   (ch_req),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant)
    );

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        nxt_ptr   = '0;
        sel_addr  = '0;
        sel_bl    = '0;
        sel_we    = 1'b0;
        wdata_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (arb_grant[i]) begin
                nxt_ptr  = (i == NUM_CH - 1) ? '0 : PTR_W'(i + 1);
                sel_addr = ch_addr[i*ADDR_W +: ADDR_W];
                sel_bl   = ch_bl[i*6 +: 6];
                sel_we   = ch_we[i];
            end
            if (grant_q[i]) wdata_sel = ch_wdata[i*DATA_W +: DATA_W];
        end
    end

    assign last_word = (cnt_q == {1'b0, bl_q});

`ifdef LPRAM_CTRL_TIMEOUT_EN
    logic [STALL_W-1:0] stall_q;
    logic               to_q;
    logic               stalled, timeout;

    assign stalled = ((state_q == WR_CMD) && bus.cmd_full) || ((state_q == RD_DATA) && bus.rd_empty);
    assign timeout = stalled && (stall_q == STALL_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
            to_q    <= 1'b0;
        end else begin
            stall_q <= stalled ? stall_q + STALL_W'(1) : '0;
            to_q    <= timeout ? 1'b1 : ((state_q == DONE) ? 1'b0 : to_q);
        end
    end

    assign err = (state_q == DONE) && to_q;
`endif

    // NOTE: state is updated with non-blocking assignments so every reader in this edge sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= WAIT_CAL;
            ptr_q   <= '0;
            grant_q <= '0;
            addr_q  <= '0;
            bl_q    <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                WAIT_CAL: if (calib_done) state_q <= IDLE;
                IDLE: begin
                    if (!calib_done) begin
                        state_q <= WAIT_CAL;
                    end else if (|ch_req) begin
                        grant_q <= arb_grant;
                        addr_q  <= sel_addr;
                        bl_q    <= sel_bl;
                        ptr_q   <= nxt_ptr;
                        cnt_q   <= '0;
                        state_q <= sel_we ? WR_DATA : RD_CMD;
                    end
                end
                WR_DATA: begin
                    if (!bus.wr_full) begin
                        cnt_q   <= last_word ? '0 : cnt_q + 7'd1;
                        state_q <= last_word ? WR_CMD : WR_DATA;
                    end
                end
                WR_CMD: begin
                    if (!bus.cmd_full) state_q <= DONE;
`ifdef LPRAM_CTRL_TIMEOUT_EN
                    else if (timeout) state_q <= DONE;
`endif
                end
                RD_CMD: if (!bus.cmd_full) state_q <= RD_DATA;
                RD_DATA: begin
                    if (!bus.rd_empty) begin
                        cnt_q   <= last_word ? '0 : cnt_q + 7'd1;
                        state_q <= last_word ? DONE : RD_DATA;
                    end
`ifdef LPRAM_CTRL_TIMEOUT_EN
                    else if (timeout) state_q <= DONE;
`endif
                end
                DONE:    state_q <= IDLE;
                default: state_q <= WAIT_CAL;
            endcase
        end
    end

    // Handshakes are decoded from registered state and gated by the FIFO flags in the same cycle.
    assign in_cmd  = (state_q == WR_CMD) || (state_q == RD_CMD);
    assign wr_fire = (state_q == WR_DATA) && !bus.wr_full;
    assign rd_fire = (state_q == RD_DATA) && !bus.rd_empty;

    assign bus.cmd_en        = in_cmd && !bus.cmd_full;
    assign bus.cmd_instr     = (state_q == RD_CMD) ? READ : WRITE;
    assign bus.cmd_bl        = in_cmd ? bl_q : '0;
    assign bus.cmd_byte_addr = in_cmd ? (addr_q & ~ADDR_W'(3)) : '0;
    assign bus.wr_en         = wr_fire;
    assign bus.wr_mask       = '0;
    assign bus.wr_data       = wr_fire ? wdata_sel : '0;
    assign bus.rd_en         = rd_fire;

    assign ch_wnext  = wr_fire ? grant_q : '0;
    assign ch_rvalid = rd_fire ? grant_q : '0;
    assign rdata     = rd_fire ? bus.rd_data : '0;
    assign ch_done   = (state_q == DONE) ? grant_q : '0;
endmodule

// File: tb/tb_lpram_port_ctrl.sv
// Directed self-checking bench for lpram_port_ctrl with a small MCB FIFO model.
module tb_lpram_port_ctrl;
    localparam int NUM_CH = 2;
    localparam int ADDR_W = 30;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [2:0]        instr;
        logic [5:0]        bl;
        logic [ADDR_W-1:0] addr;
    } cmd_t;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     calib_done;
    logic [NUM_CH-1:0]        ch_req, ch_we;
    logic [NUM_CH*ADDR_W-1:0] ch_addr;
    logic [NUM_CH*6-1:0]      ch_bl;
    logic [NUM_CH*DATA_W-1:0] ch_wdata;
    logic [NUM_CH-1:0]        ch_wnext, ch_rvalid, ch_done;
    logic [DATA_W-1:0]        rdata;
`ifdef LPRAM_CTRL_TIMEOUT_EN
    logic                     err;
`endif

    lpram_port_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    lpram_port_ctrl #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .calib_done (calib_done),
        .ch_req     (ch_req),
        .ch_we      (ch_we),
        .ch_addr    (ch_addr),
        .ch_bl      (ch_bl),
        .ch_wdata   (ch_wdata),
        .ch_wnext   (ch_wnext),
        .ch_rvalid  (ch_rvalid),
        .rdata      (rdata),
        .ch_done    (ch_done),
        .bus        (bus)
`ifdef LPRAM_CTRL_TIMEOUT_EN
        ,
        .err        (err)
`endif
    );

    always #5 clk = ~clk;

    // MCB read FIFO model: words A000_0000 + n, advancing on each rd_en.
    int   rd_cnt = 0;
    int   rd_mode = 0;
    logic tog = 1'b0;
    always @(posedge clk) begin
        tog <= ~tog;
        if (bus.rd_en) rd_cnt <= rd_cnt + 1;
    end
    assign bus.rd_data  = 32'hA000_0000 + 32'(rd_cnt);
    assign bus.rd_empty = (rd_mode == 2) || ((rd_mode == 1) && tog);

    // Client write sources: a fresh word after every ch_wnext.
    int wd0 = 0, wd1 = 0;
    always @(posedge clk) begin
        if (ch_wnext[0]) wd0 <= wd0 + 1;
        if (ch_wnext[1]) wd1 <= wd1 + 1;
    end
    assign ch_wdata = {32'hC001_0000 + 32'(wd1), 32'hC000_0000 + 32'(wd0)};

    int          cyc = 0;
    logic [31:0] wr_log[$];
    logic [1:0]  wnext_log[$];
    int          wr_stamp[$];
    cmd_t        cmd_log[$];
    int          cmd_stamp[$];
    logic [31:0] rv_log[$];
    logic [1:0]  rvv_log[$];
    logic [1:0]  done_log[$];
    int          done_stamp[$];
    logic        err_log[$];

    always @(negedge clk) begin
        cyc++;
        if (bus.wr_en || (|ch_wnext)) begin
            wr_log.push_back(bus.wr_data);
            wnext_log.push_back(ch_wnext);
            wr_stamp.push_back(cyc);
        end
        if (bus.cmd_en) begin
            cmd_log.push_back({bus.cmd_instr, bus.cmd_bl, bus.cmd_byte_addr});
            cmd_stamp.push_back(cyc);
        end
        if (bus.rd_en || (|ch_rvalid)) begin
            rv_log.push_back(rdata);
            rvv_log.push_back(ch_rvalid);
        end
        if (|ch_done) begin
            done_log.push_back(ch_done);
            done_stamp.push_back(cyc);
`ifdef LPRAM_CTRL_TIMEOUT_EN
            err_log.push_back(err);
`else
            err_log.push_back(1'b0);
`endif
        end
    end

    int tests_run = 0;
    int tests_failed = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        wr_log.delete(); wnext_log.delete(); wr_stamp.delete();
        cmd_log.delete(); cmd_stamp.delete();
        rv_log.delete(); rvv_log.delete();
        done_log.delete(); done_stamp.delete(); err_log.delete();
    endtask

    task automatic wait_dones(input string tag, input int n, input int budget);
        int c = 0;
        while (done_log.size() < n && c < budget) begin
            step(1);
            c++;
        end
        chk(tag, 64'(done_log.size()), 64'(n));
    endtask

    task automatic chk_cmd(input string tag, input logic [2:0] instr, input logic [5:0] bl,
                           input logic [ADDR_W-1:0] addr);
        chk({tag, "_count"}, 64'(cmd_log.size()), 64'd1);
        if (cmd_log.size() >= 1) chk({tag, "_fields"}, 64'(cmd_log[0]), 64'({instr, bl, addr}));
    endtask

    int          base, n_before, rel_cyc, c;
    logic [1:0]  rr_exp[4] = '{2'b01, 2'b10, 2'b01, 2'b10};

    initial begin
        rst = 1'b1; calib_done = 1'b0; ch_req = '0; ch_we = '0; ch_addr = '0; ch_bl = '0;
        bus.cmd_full = 1'b0; bus.wr_full = 1'b0;
        step(2);
        chk("rst_outputs", 64'({ch_wnext, ch_rvalid, ch_done, rdata, bus.cmd_en, bus.wr_en, bus.rd_en}), 64'd0);
        chk("rst_cmd_bus", 64'({bus.cmd_instr, bus.cmd_bl, bus.cmd_byte_addr}), 64'd0);
        chk("rst_wr_bus", 64'({bus.wr_mask, bus.wr_data}), 64'd0);
        rst = 1'b0;

        // Calibration held low: a pending ch0 write must not start.
        ch_addr[29:0] = 30'h103; ch_bl[5:0] = 6'd3; ch_we = 2'b01; ch_req = 2'b01;
        clear_logs();
        step(50);
        chk("nocal_cmd", 64'(cmd_log.size()), 64'd0);
        chk("nocal_wnext", 64'(wr_log.size()), 64'd0);
        chk("nocal_rvalid", 64'(rv_log.size()), 64'd0);
        chk("nocal_done", 64'(done_log.size()), 64'd0);

        // ch0 write, 4 words, then command at 0x100.
        base = wd0;
        calib_done = 1'b1;
        wait_dones("wr_done_wait", 1, 100);
        ch_req = '0;
        chk("wr_words", 64'(wr_log.size()), 64'd4);
        for (int k = 0; k < wr_log.size() && k < 4; k++) begin
            chk("wr_data", 64'(wr_log[k]), 64'(32'hC000_0000 + 32'(base + k)));
            chk("wr_wnext", 64'(wnext_log[k]), 64'(2'b01));
        end
        chk_cmd("wr_cmd", 3'b000, 6'd3, 30'h100);
        if (cmd_stamp.size() >= 1 && wr_stamp.size() >= 4)
            chk("wr_cmd_after_data", 64'(cmd_stamp[0] > wr_stamp[3]), 64'd1);
        if (done_log.size() >= 1) chk("wr_done_ch", 64'(done_log[0]), 64'(2'b01));

        // ch1 read, 8 words with rd_empty toggling.
        clear_logs();
        base = rd_cnt;
        ch_addr[59:30] = 30'h2005; ch_bl[11:6] = 6'd7; ch_we = 2'b00; rd_mode = 1; ch_req = 2'b10;
        wait_dones("rd_done_wait", 1, 200);
        ch_req = '0; rd_mode = 0;
        chk("rd_words", 64'(rv_log.size()), 64'd8);
        for (int k = 0; k < rv_log.size() && k < 8; k++) begin
            chk("rd_data", 64'(rv_log[k]), 64'(32'hA000_0000 + 32'(base + k)));
            chk("rd_rvalid", 64'(rvv_log[k]), 64'(2'b10));
        end
        chk_cmd("rd_cmd", 3'b001, 6'd7, 30'h2004);
        if (done_log.size() >= 1) chk("rd_done_ch", 64'(done_log[0]), 64'(2'b10));

        // Both channels requesting: grants alternate starting at channel 0.
        clear_logs();
        ch_bl = '0; ch_we = 2'b01; ch_req = 2'b11;
        wait_dones("rr_wait", 4, 200);
        ch_req = '0;
        for (int k = 0; k < done_log.size() && k < 4; k++)
            chk("rr_order", 64'(done_log[k]), 64'(rr_exp[k]));

        // wr_full held for 10 cycles mid-burst.
        clear_logs();
        base = wd0;
        ch_bl[5:0] = 6'd7; ch_we = 2'b01; ch_req = 2'b01;
        c = 0;
        while (wr_log.size() < 3 && c < 50) begin step(1); c++; end
        chk("stall_reach", 64'(wr_log.size() >= 3), 64'd1);
        bus.wr_full = 1'b1;
        n_before = wr_log.size();
        step(10);
        chk("stall_no_wr", 64'(wr_log.size()), 64'(n_before));
        chk("stall_wr_en", 64'(bus.wr_en), 64'd0);
        bus.wr_full = 1'b0;
        wait_dones("stall_done_wait", 1, 100);
        ch_req = '0;
        chk("stall_words", 64'(wr_log.size()), 64'd8);
        for (int k = 0; k < wr_log.size() && k < 8; k++)
            chk("stall_data", 64'(wr_log[k]), 64'(32'hC000_0000 + 32'(base + k)));
        if (done_log.size() >= 1) chk("stall_done_ch", 64'(done_log[0]), 64'(2'b01));

        // Maximum burst: bl=63 read on ch0, 64 words.
        clear_logs();
        base = rd_cnt;
        ch_bl[5:0] = 6'd63; ch_we = 2'b00; ch_addr[29:0] = 30'h3FF; ch_req = 2'b01;
        wait_dones("bl63_done_wait", 1, 300);
        ch_req = '0;
        chk("bl63_words", 64'(rv_log.size()), 64'd64);
        for (int k = 0; k < rv_log.size() && k < 64; k++)
            chk("bl63_data", 64'(rv_log[k]), 64'(32'hA000_0000 + 32'(base + k)));
        chk_cmd("bl63_cmd", 3'b001, 6'd63, 30'h3FC);

        // Reset in the middle of a read burst.
        clear_logs();
        ch_req = 2'b01;
        c = 0;
        while (rv_log.size() < 5 && c < 50) begin step(1); c++; end
        chk("midrst_reach", 64'(rv_log.size() >= 5), 64'd1);
        rst = 1'b1;
        #1;
        chk("midrst_outputs", 64'({ch_wnext, ch_rvalid, ch_done, rdata, bus.cmd_en, bus.wr_en, bus.rd_en}), 64'd0);
        chk("midrst_cmd_bus", 64'({bus.cmd_instr, bus.cmd_bl, bus.cmd_byte_addr}), 64'd0);
        ch_req = '0;
        step(2);
        chk("midrst_no_done", 64'(done_log.size()), 64'd0);
        clear_logs();
        ch_bl = '0; ch_we = 2'b00; ch_req = 2'b11;
        rst = 1'b0;
        rel_cyc = cyc;
        wait_dones("postrst_done_wait", 1, 50);
        ch_req = '0;
        if (done_log.size() >= 1) chk("postrst_ptr0", 64'(done_log[0]), 64'(2'b01));
        if (cmd_stamp.size() >= 1) chk("postrst_wait_cal", 64'(cmd_stamp[0] - rel_cyc), 64'd3);
        if (err_log.size() >= 1) chk("postrst_no_err", 64'(err_log[0]), 64'd0);

`ifdef LPRAM_CTRL_TIMEOUT_EN
        // Read FIFO never fills: timeout after 1024 stalled cycles.
        step(2);
        clear_logs();
        rd_mode = 2; ch_we = 2'b00; ch_bl = '0; ch_req = 2'b10;
        wait_dones("to_done_wait", 1, 1200);
        ch_req = '0; rd_mode = 0;
        chk("to_rvalid", 64'(rv_log.size()), 64'd0);
        if (err_log.size() >= 1) chk("to_err", 64'(err_log[0]), 64'd1);
        if (done_log.size() >= 1 && cmd_stamp.size() >= 1)
            chk("to_latency", 64'(done_stamp[0] - cmd_stamp[0]), 64'd1025);
        step(2);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
